keccak_padder: RTL

Upstream stage of the `keccak` sponge core. Accepts a message as a byte stream with a valid/ready handshake, assembles rate-sized (r-bit) blocks, and applies SHA-3 domain separation plus pad10*1 padding (0x06 … 0x80). Emits blocks on a valid/ready handshake, with first/last flags so the control logic can clear the sponge state and capture the digest.

---
 rtl/keccak_padder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/keccak_padder.sv
// SHA-3 message padder: packs a byte stream into r-bit blocks, adds 0x06 domain bits and pad10*1.
// Latency: a block is presented the cycle after the beat that completes it; the pad-only block follows its predecessor's handshake.
// Backpressure: in_ready is low while a block is held; the held block and flags stay stable until msg_ready.
// Ports: clk/reset (async, active-high); in_data/in_valid/in_ready/in_last/in_null byte input;
//        message/msg_valid/msg_ready/msg_first/msg_last block output (byte k at message[8k+:8]).
module keccak_padder #(
  parameter int d = 112,
  parameter int l = 6,
  parameter int w = 2**l,
  parameter int b = 25*w,
  parameter int c = 2*d,
  parameter int r = b - c
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic         in_null,
  output logic [r-1:0] message,
  output logic         msg_valid,
  input  logic         msg_ready,
  output logic         msg_first,
  output logic         msg_last
);

  localparam int R  = r / 8;
  localparam int IW = (R > 1) ? $clog2(R) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(R - 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t        state_q, state_d;
  logic [r-1:0]  blk_q, blk_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic          pad_pending_q, pad_pending_d;
  logic [IW-1:0] idx_inc;

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    blk_d         = blk_q;
    idx_d         = idx_q;
    first_d       = first_q;
    last_d        = last_q;
    pad_pending_d = pad_pending_q;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          // The buffer is all-zero on entry to FILL, so XOR places the pad bytes exactly
          // and merges 0x06/0x80 into 0x86 when they land on the same byte.
          if (in_null) begin
            blk_d[{idx_q, 3'b000} +: 8] = blk_d[{idx_q, 3'b000} +: 8] ^ 8'h06;
            blk_d[r-8 +: 8]             = blk_d[r-8 +: 8] ^ 8'h80;
            state_d = FULL;
            last_d  = 1'b1;
          end else begin
            blk_d[{idx_q, 3'b000} +: 8] = in_data;
            if (idx_q == LAST_IDX) begin
              // A last byte that fills the block leaves no room for padding: defer it
              // to an extra pad-only block.
              state_d       = FULL;
              last_d        = 1'b0;
              pad_pending_d = in_last;
            end else if (in_last) begin
              blk_d[{idx_inc, 3'b000} +: 8] = blk_d[{idx_inc, 3'b000} +: 8] ^ 8'h06;
              blk_d[r-8 +: 8]               = blk_d[r-8 +: 8] ^ 8'h80;
              state_d = FULL;
              last_d  = 1'b1;
            end else begin
              idx_d = idx_inc;
            end
          end
        end
      end
      FULL: begin
        if (msg_ready) begin
          // The block after a final block starts a new message.
          first_d = last_q;
          if (pad_pending_q) begin
            blk_d           = '0;
            blk_d[7:0]      = 8'h06;
            blk_d[r-8 +: 8] = blk_d[r-8 +: 8] | 8'h80;
            last_d          = 1'b1;
            pad_pending_d   = 1'b0;
          end else begin
            blk_d   = '0;
            idx_d   = '0;
            last_d  = 1'b0;
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FILL;
      blk_q         <= '0;
      idx_q         <= '0;
      first_q       <= 1'b1;
      last_q        <= 1'b0;
      pad_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      blk_q         <= blk_d;
      idx_q         <= idx_d;
      first_q       <= first_d;
      last_q        <= last_d;
      pad_pending_q <= pad_pending_d;
    end
  end

  // Outputs come straight from flops; in_ready depends on the state only (and is held low in reset).
  assign in_ready  = (state_q == FILL) && !reset;
  assign msg_valid = (state_q == FULL);
  assign message   = blk_q;
  assign msg_first = first_q;
  assign msg_last  = last_q;

endmodule
